// File: rtl/dpram_fifo_pkg.sv
// Shared geometry for the 64-deep distributed-RAM FIFO.
package dpram_fifo_pkg;
   localparam int FIFO_DEPTH = 64;
   localparam int FIFO_AW    = 6;
   localparam int FIFO_CW    = 7;
endpackage

// File: rtl/dpram_fifo_bank.sv
// WIDTH slices of a 64x1 dual-port RAM: synchronous write port, asynchronous read port.
module dpram_fifo_bank
   import dpram_fifo_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               CLK,
   input  logic               we,
   input  logic [FIFO_AW-1:0] wa,
   input  logic [FIFO_AW-1:0] ra,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout
);
   for (genvar b = 0; b < WIDTH; b++) begin : g_cell
      logic [FIFO_DEPTH-1:0] mem_q, mem_d;

      always_comb begin
         mem_d = mem_q;
         if (we) mem_d[wa] = din[b];
      end

      // Contents are deliberately not reset, matching the RAM primitive.
      always_ff @(posedge CLK) mem_q <= mem_d;

      assign dout[b] = mem_q[ra];
   end
endmodule

// File: rtl/dpram_fifo.sv
// FIFO controller: pointers, occupancy count and flags around a dpram_fifo_bank;
// read data falls through from the head entry.
module dpram_fifo
   import dpram_fifo_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int AFULL_LEVEL = 48
) (
   input  logic               CLK,
   input  logic               Reset_n,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   wr_data,
   output logic               full,
   output logic               almost_full,
   input  logic               rd_en,
   output logic [WIDTH-1:0]   rd_data,
   output logic               empty,
   output logic [FIFO_CW-1:0] count,
   output logic               overflow,
   output logic               underflow
);
   localparam logic [FIFO_CW-1:0] AFULL_C = FIFO_CW'(AFULL_LEVEL);
   localparam logic [FIFO_CW-1:0] DEPTH_C = FIFO_CW'(FIFO_DEPTH);

   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_CW-1:0] count_q, count_d;
   logic               empty_q, empty_d, full_q, full_d, afull_q, afull_d;
   logic               ovf_q, ovf_d, unf_q, unf_d;
   logic               wa_ok, rd_ok, ram_we;
   logic [WIDTH-1:0]   ram_out;

   // Acceptance looks only at registered flags, never at the other port.
   assign wa_ok = wr_en & ~full_q;
   assign rd_ok = rd_en & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wa_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      case ({wa_ok, rd_ok})
         2'b10:   count_d = count_q + FIFO_CW'(1);
         2'b01:   count_d = count_q - FIFO_CW'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_C);
      afull_d = (count_d >= AFULL_C);
      ovf_d   = ovf_q | (wr_en & full_q);
      unf_d   = unf_q | (rd_en & empty_q);
   end

   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // No RAM writes land while reset is held.
   assign ram_we = wa_ok & Reset_n;

   dpram_fifo_bank #(.WIDTH(WIDTH)) u_bank (
      .CLK  (CLK),
      .we   (ram_we),
      .wa   (wr_ptr_q),
      .ra   (rd_ptr_q),
      .din  (wr_data),
      .dout (ram_out)
   );

   assign rd_data     = empty_q ? '0 : ram_out;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign empty       = empty_q;
   assign count       = count_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;
endmodule

// File: tb/tb_dpram_fifo.sv
// Randomized self-checking bench for dpram_fifo against a queue-based reference model.
module tb_dpram_fifo;
   localparam int WIDTH = 32;
   localparam int AFL   = 48;

   logic             CLK = 1'b0;
   logic             Reset_n = 1'b0;
   logic             wr_en = 1'b0, rd_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             full, almost_full, empty, overflow, underflow;
   logic [WIDTH-1:0] rd_data;
   logic [6:0]       count;

   int checks = 0;
   int failures = 0;

   logic [WIDTH-1:0] mq[$];
   bit m_ovf, m_unf;

   always #5 CLK = ~CLK;

   dpram_fifo #(.WIDTH(WIDTH), .AFULL_LEVEL(AFL)) dut (
      .CLK(CLK), .Reset_n(Reset_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
      .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   function automatic logic [WIDTH-1:0] m_head();
      return (mq.size() != 0) ? mq[0] : '0;
   endfunction

   // One clock: drive inputs, advance the model by the FIFO rules, sample 1 time unit after the edge.
   task automatic cycle(input bit rst_n, input bit we, input logic [WIDTH-1:0] wd, input bit re);
      bit m_full, m_empty;
      Reset_n = rst_n; wr_en = we; wr_data = wd; rd_en = re;
      @(posedge CLK);
      m_full  = (mq.size() == 64);
      m_empty = (mq.size() == 0);
      if (!rst_n) begin
         mq.delete(); m_ovf = 0; m_unf = 0;
      end else begin
         if (we && m_full)  m_ovf = 1;
         if (re && m_empty) m_unf = 1;
         if (re && !m_empty) void'(mq.pop_front());
         if (we && !m_full)  mq.push_back(wd);
      end
      #1;
      Reset_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_reset();
      cycle(0, 1, 32'hDEAD, 1);
      checks++; if (count !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if ({empty, full, almost_full, overflow, underflow} !== 5'b10000) begin
         failures++; $display("FAIL reset_flags got=%b exp=10000", {empty, full, almost_full, overflow, underflow}); end
      checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] pat[3];
      pat[0] = 32'h11; pat[1] = 32'h22; pat[2] = 32'h33;
      cycle(0, 0, 0, 0);
      cycle(1, 1, pat[0], 0);
      checks++; if (empty !== 1'b0) begin failures++; $display("FAIL basic_empty_fall got=%b exp=0", empty); end
      checks++; if (rd_data !== 32'h11) begin failures++; $display("FAIL basic_fwft got=%h exp=11", rd_data); end
      cycle(1, 1, pat[1], 0);
      cycle(1, 1, pat[2], 0);
      checks++; if (count !== 7'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (rd_data !== pat[i]) begin failures++; $display("FAIL basic_read%0d got=%h exp=%h", i, rd_data, pat[i]); end
         cycle(1, 0, 0, 1);
      end
      checks++; if (empty !== 1'b1 || rd_data !== '0) begin
         failures++; $display("FAIL basic_drained empty=%b rd=%h exp empty=1 rd=0", empty, rd_data); end
   endtask

   task automatic test_fill_overflow();
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 64; i++) begin
         cycle(1, 1, WIDTH'(i), 0);
         if (i == 46 || i == 47) begin
            checks++; if (almost_full !== (i == 47)) begin
               failures++; $display("FAIL fill_afull after=%0d got=%b exp=%b", i + 1, almost_full, i == 47); end
         end
         if (i == 62 || i == 63) begin
            checks++; if (full !== (i == 63)) begin
               failures++; $display("FAIL fill_full after=%0d got=%b exp=%b", i + 1, full, i == 63); end
         end
      end
      cycle(1, 1, 32'hAA, 0);
      checks++; if (overflow !== 1'b1 || count !== 7'd64) begin
         failures++; $display("FAIL fill_overflow ovf=%b count=%0d exp ovf=1 count=64", overflow, count); end
      for (int i = 0; i < 64; i++) begin
         checks++; if (rd_data !== WIDTH'(i)) begin failures++; $display("FAIL drain_data idx=%0d got=%h exp=%h", i, rd_data, i); end
         cycle(1, 0, 0, 1);
      end
      checks++; if (empty !== 1'b1 || rd_data !== '0) begin
         failures++; $display("FAIL drain_end empty=%b rd=%h exp empty=1 rd=0", empty, rd_data); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] nxt;
      cycle(0, 0, 0, 0);
      nxt = $urandom;
      for (int i = 0; i < 10; i++) begin cycle(1, 1, nxt, 0); nxt++; end
      for (int i = 0; i < 100; i++) begin
         cycle(1, 1, nxt, 1); nxt++;
         checks++; if (count !== 7'd10 || rd_data !== m_head()) begin
            failures++; $display("FAIL stream cyc=%0d count=%0d rd=%h exp count=10 rd=%h", i, count, rd_data, m_head()); end
      end
   endtask

   task automatic test_full_both();
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 64; i++) cycle(1, 1, $urandom, 0);
      cycle(1, 1, 32'hBB, 1);
      checks++; if (count !== 7'd63 || full !== 1'b0 || overflow !== 1'b1) begin
         failures++; $display("FAIL full_both count=%0d full=%b ovf=%b exp 63/0/1", count, full, overflow); end
      checks++; if (rd_data !== m_head()) begin failures++; $display("FAIL full_both_head got=%h exp=%h", rd_data, m_head()); end
   endtask

   task automatic test_empty_both();
      cycle(0, 0, 0, 0);
      cycle(1, 1, 32'h5, 1);
      checks++; if (count !== 7'd1 || rd_data !== 32'h5 || underflow !== 1'b1 || overflow !== 1'b0) begin
         failures++; $display("FAIL empty_both count=%0d rd=%h unf=%b ovf=%b exp 1/5/1/0", count, rd_data, underflow, overflow); end
   endtask

   task automatic test_reset_mid();
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle(1, 1, $urandom, 0);
      cycle(1, 1, 32'h1, 1);
      cycle(1, 1, 32'h2, 1);
      cycle(0, 1, 32'h3, 1);
      checks++; if (count !== 7'd0 || {empty, full, almost_full, overflow, underflow} !== 5'b10000) begin
         failures++; $display("FAIL midreset count=%0d flags=%b exp 0/10000", count, {empty, full, almost_full, overflow, underflow}); end
      cycle(1, 1, 32'h77, 0);
      checks++; if (rd_data !== 32'h77 || count !== 7'd1) begin
         failures++; $display("FAIL midreset_first rd=%h count=%0d exp 77/1", rd_data, count); end
   endtask

   task automatic test_random();
      bit we, re, rn;
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         rn = ($urandom_range(0, 199) != 0);
         // Bias write/read rates per phase so both full and empty get visited.
         we = ($urandom_range(0, 99) < ((i / 300) % 2 ? 30 : 75));
         re = ($urandom_range(0, 99) < ((i / 300) % 2 ? 75 : 30));
         cycle(rn, we, $urandom, re);
         checks++;
         if (count !== 7'(mq.size()) || rd_data !== m_head() || empty !== (mq.size() == 0) ||
             full !== (mq.size() == 64) || almost_full !== (mq.size() >= AFL) ||
             overflow !== m_ovf || underflow !== m_unf) begin
            failures++;
            $display("FAIL random cyc=%0d count=%0d/%0d rd=%h/%h e=%b f=%b af=%b ovf=%b/%b unf=%b/%b",
                     i, count, mq.size(), rd_data, m_head(), empty, full, almost_full,
                     overflow, m_ovf, underflow, m_unf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_back_to_back();
      test_full_both();
      test_empty_both();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
